// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states,
// operand-forwarding selects and the hardwired-zero register address.
package pipeline_hazard_controller_pkg;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [2:0] REG_ZERO = 3'd0;

  // A producer only counts as a hazard/forward source if it writes a real register.
  function automatic logic reg_hit(input logic       wr_en,
                                   input logic [2:0] wr_reg,
                                   input logic [2:0] rd_reg);
    return wr_en && (wr_reg != REG_ZERO) && (wr_reg == rd_reg);
  endfunction

endpackage

// File: rtl/pipeline_hazard_controller_forward_select.sv
// EX operand forwarding select for one source operand; the newer EX/MEM
// result takes precedence over the older MEM/WB result.
module pipeline_hazard_controller_forward_select
  import pipeline_hazard_controller_pkg::*;
(
  input  logic [2:0] i_ex_src,
  input  logic [2:0] i_mem_write_reg,
  input  logic       i_mem_reg_write,
  input  logic [2:0] i_wb_write_reg,
  input  logic       i_wb_reg_write,
  output logic [1:0] o_forward
);

  always_comb begin
    o_forward = FWD_RF;
    if (reg_hit(i_mem_reg_write, i_mem_write_reg, i_ex_src)) begin
      o_forward = FWD_MEM;
    end else if (reg_hit(i_wb_reg_write, i_wb_write_reg, i_ex_src)) begin
      o_forward = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush/forwarding sequencer for the 5-stage pipeline, with a
// MEM_WAIT freeze state machine, sticky wait timeout and event counters.
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int unsigned WAIT_TIMEOUT = 64,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       i_id_rs,
  input  logic [2:0]       i_id_rt,
  input  logic             i_id_uses_rs,
  input  logic             i_id_uses_rt,
  input  logic             i_id_jump,
  input  logic [2:0]       i_ex_rs,
  input  logic [2:0]       i_ex_rt,
  input  logic [2:0]       i_ex_write_reg,
  input  logic             i_ex_reg_write,
  input  logic             i_ex_mem_read,
  input  logic             i_ex_branch_taken,
  input  logic [2:0]       i_mem_write_reg,
  input  logic             i_mem_reg_write,
  input  logic [2:0]       i_wb_write_reg,
  input  logic             i_wb_reg_write,
  input  logic             i_mem_busy,
  output logic             o_pc_enable,
  output logic             o_if_id_enable,
  output logic             o_if_id_clr,
  output logic             o_id_ex_enable,
  output logic             o_id_ex_clr,
  output logic             o_back_enable,
  output logic [1:0]       o_forward_a,
  output logic [1:0]       o_forward_b,
  output logic             o_mem_timeout,
  output logic [CNT_W-1:0] o_stall_count,
  output logic [CNT_W-1:0] o_flush_count,
  output logic [CNT_W-1:0] o_wait_count,
  output state_t           o_state
);

  // Handshake-free block: every output is a level valid in the cycle its inputs are.
  state_t           r_state;
  state_t           w_state_next;
  logic [15:0]      r_wait_cnt;
  logic [15:0]      w_wait_inc;
  logic             r_mem_timeout;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic [CNT_W-1:0] r_wait_total;
  logic             w_load_use;
  logic             w_stall_evt;
  logic             w_flush_evt;
  logic             w_freeze;

  assign w_load_use = i_ex_mem_read &&
                      (reg_hit(i_ex_reg_write, i_ex_write_reg, i_id_rs) && i_id_uses_rs ||
                       reg_hit(i_ex_reg_write, i_ex_write_reg, i_id_rt) && i_id_uses_rt);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN:      if (i_mem_busy)  w_state_next = ST_MEM_WAIT;
      ST_MEM_WAIT: if (!i_mem_busy) w_state_next = ST_RUN;
      default:     w_state_next = ST_RUN;
    endcase
  end

  // Priority: freeze > branch > load-use > jump (a jump re-evaluates after the stall).
  always_comb begin
    o_pc_enable    = 1'b1;
    o_if_id_enable = 1'b1;
    o_if_id_clr    = 1'b0;
    o_id_ex_enable = 1'b1;
    o_id_ex_clr    = 1'b0;
    o_back_enable  = 1'b1;
    w_stall_evt    = 1'b0;
    w_flush_evt    = 1'b0;
    w_freeze       = 1'b0;
    if (!rst) begin
      if (i_mem_busy) begin
        w_freeze       = 1'b1;
        o_pc_enable    = 1'b0;
        o_if_id_enable = 1'b0;
        o_id_ex_enable = 1'b0;
        o_back_enable  = 1'b0;
      end else if (i_ex_branch_taken) begin
        o_if_id_clr = 1'b1;
        o_id_ex_clr = 1'b1;
        w_flush_evt = 1'b1;
      end else if (w_load_use) begin
        o_pc_enable    = 1'b0;
        o_if_id_enable = 1'b0;
        o_id_ex_clr    = 1'b1;
        w_stall_evt    = 1'b1;
      end else if (i_id_jump) begin
        o_if_id_clr = 1'b1;
        w_flush_evt = 1'b1;
      end
    end
  end

  // Wait counter holds the number of consecutive frozen cycles completed.
  assign w_wait_inc = (r_wait_cnt == 16'hFFFF) ? r_wait_cnt : r_wait_cnt + 16'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
      r_stall_cnt   <= '0;
      r_flush_cnt   <= '0;
      r_wait_total  <= '0;
    end else begin
      if (w_freeze) begin
        r_wait_cnt <= w_wait_inc;
        if (w_wait_inc >= 16'(WAIT_TIMEOUT)) r_mem_timeout <= 1'b1;
      end else begin
        r_wait_cnt <= '0;
      end
      if (w_stall_evt && (r_stall_cnt != '1)) r_stall_cnt  <= r_stall_cnt + CNT_W'(1);
      if (w_flush_evt && (r_flush_cnt != '1)) r_flush_cnt  <= r_flush_cnt + CNT_W'(1);
      if (w_freeze && (r_wait_total != '1))   r_wait_total <= r_wait_total + CNT_W'(1);
    end
  end

  pipeline_hazard_controller_forward_select u_forward_select_a (
    .i_ex_src        (i_ex_rs),
    .i_mem_write_reg (i_mem_write_reg),
    .i_mem_reg_write (i_mem_reg_write),
    .i_wb_write_reg  (i_wb_write_reg),
    .i_wb_reg_write  (i_wb_reg_write),
    .o_forward       (o_forward_a)
  );

  pipeline_hazard_controller_forward_select u_forward_select_b (
    .i_ex_src        (i_ex_rt),
    .i_mem_write_reg (i_mem_write_reg),
    .i_mem_reg_write (i_mem_reg_write),
    .i_wb_write_reg  (i_wb_write_reg),
    .i_wb_reg_write  (i_wb_reg_write),
    .o_forward       (o_forward_b)
  );

  assign o_mem_timeout = r_mem_timeout;
  assign o_stall_count = r_stall_cnt;
  assign o_flush_count = r_flush_cnt;
  assign o_wait_count  = r_wait_total;
  assign o_state       = r_state;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Randomized + directed bench for pipeline_hazard_controller against a
// cycle-level behavioural model of the stall/flush/forward/wait rules.
module tb_pipeline_hazard_controller;
  import pipeline_hazard_controller_pkg::*;

  localparam int WT    = 4;
  localparam int CNT_W = 6;
  localparam int CMAX  = (1 << CNT_W) - 1;

  typedef struct packed {
    logic       rst, busy, branch, jump;
    logic       uses_rs, uses_rt, ex_mem_read, ex_reg_write, mem_reg_write, wb_reg_write;
    logic [2:0] id_rs, id_rt, ex_rs, ex_rt, ex_wr, mem_wr, wb_wr;
  } in_t;

  typedef struct packed {
    logic             pc_en, ifid_en, ifid_clr, idex_en, idex_clr, back_en;
    logic [1:0]       fa, fb;
    logic             timeout, state;
    logic [CNT_W-1:0] stall, flush, waitc;
  } out_t;

  localparam int OW = $bits(out_t);

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [2:0] id_rs, id_rt, ex_rs, ex_rt, ex_write_reg, mem_write_reg, wb_write_reg;
  logic id_uses_rs, id_uses_rt, id_jump, ex_reg_write, ex_mem_read, ex_branch_taken;
  logic mem_reg_write, wb_reg_write, mem_busy;
  logic pc_enable, if_id_enable, if_id_clr, id_ex_enable, id_ex_clr, back_enable, mem_timeout;
  logic [1:0] forward_a, forward_b;
  logic [CNT_W-1:0] stall_count, flush_count, wait_count;
  state_t dut_state;

  pipeline_hazard_controller #(.WAIT_TIMEOUT(WT), .CNT_W(CNT_W)) dut (
    .clk               (clk),
    .rst               (rst),
    .i_id_rs           (id_rs),
    .i_id_rt           (id_rt),
    .i_id_uses_rs      (id_uses_rs),
    .i_id_uses_rt      (id_uses_rt),
    .i_id_jump         (id_jump),
    .i_ex_rs           (ex_rs),
    .i_ex_rt           (ex_rt),
    .i_ex_write_reg    (ex_write_reg),
    .i_ex_reg_write    (ex_reg_write),
    .i_ex_mem_read     (ex_mem_read),
    .i_ex_branch_taken (ex_branch_taken),
    .i_mem_write_reg   (mem_write_reg),
    .i_mem_reg_write   (mem_reg_write),
    .i_wb_write_reg    (wb_write_reg),
    .i_wb_reg_write    (wb_reg_write),
    .i_mem_busy        (mem_busy),
    .o_pc_enable       (pc_enable),
    .o_if_id_enable    (if_id_enable),
    .o_if_id_clr       (if_id_clr),
    .o_id_ex_enable    (id_ex_enable),
    .o_id_ex_clr       (id_ex_clr),
    .o_back_enable     (back_enable),
    .o_forward_a       (forward_a),
    .o_forward_b       (forward_b),
    .o_mem_timeout     (mem_timeout),
    .o_stall_count     (stall_count),
    .o_flush_count     (flush_count),
    .o_wait_count      (wait_count),
    .o_state           (dut_state)
  );

  // ---------------- scoreboard state ----------------
  logic [OW-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Behavioural model: what has happened so far, not how the RTL stores it.
  bit m_was_busy;
  int m_busy_run, m_stall, m_flush, m_waitc;
  bit m_timeout;

  function automatic logic [1:0] model_fwd(logic [2:0] src, in_t v);
    if (v.mem_reg_write && v.mem_wr != 0 && v.mem_wr == src) return 2'b10;
    if (v.wb_reg_write && v.wb_wr != 0 && v.wb_wr == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic in_t idle();
    in_t v;
    v = '0;
    return v;
  endfunction

  // ---------------- driver ----------------
  task automatic apply(in_t v);
    rst = v.rst; mem_busy = v.busy; ex_branch_taken = v.branch; id_jump = v.jump;
    id_uses_rs = v.uses_rs; id_uses_rt = v.uses_rt; ex_mem_read = v.ex_mem_read;
    ex_reg_write = v.ex_reg_write; mem_reg_write = v.mem_reg_write; wb_reg_write = v.wb_reg_write;
    id_rs = v.id_rs; id_rt = v.id_rt; ex_rs = v.ex_rs; ex_rt = v.ex_rt;
    ex_write_reg = v.ex_wr; mem_write_reg = v.mem_wr; wb_write_reg = v.wb_wr;
  endtask

  task automatic model_step(in_t v);
    out_t e;
    bit lu;
    lu = v.ex_mem_read && v.ex_reg_write && v.ex_wr != 0 &&
         ((v.uses_rs && v.id_rs == v.ex_wr) || (v.uses_rt && v.id_rt == v.ex_wr));
    e = '0;
    {e.pc_en, e.ifid_en, e.idex_en, e.back_en} = 4'b1111;
    e.fa      = model_fwd(v.ex_rs, v);
    e.fb      = model_fwd(v.ex_rt, v);
    e.timeout = m_timeout;
    e.state   = m_was_busy;
    e.stall   = CNT_W'(m_stall);
    e.flush   = CNT_W'(m_flush);
    e.waitc   = CNT_W'(m_waitc);
    if (v.rst) begin
      m_was_busy = 0; m_busy_run = 0; m_timeout = 0; m_stall = 0; m_flush = 0; m_waitc = 0;
    end else begin
      if (v.busy) begin
        {e.pc_en, e.ifid_en, e.idex_en, e.back_en} = 4'b0000;
        m_busy_run++;
        if (m_busy_run >= WT) m_timeout = 1;
        if (m_waitc < CMAX) m_waitc++;
      end else begin
        m_busy_run = 0;
        if (v.branch) begin
          e.ifid_clr = 1; e.idex_clr = 1;
          if (m_flush < CMAX) m_flush++;
        end else if (lu) begin
          e.pc_en = 0; e.ifid_en = 0; e.idex_clr = 1;
          if (m_stall < CMAX) m_stall++;
        end else if (v.jump) begin
          e.ifid_clr = 1;
          if (m_flush < CMAX) m_flush++;
        end
      end
      m_was_busy = v.busy;
    end
    exp_q.push_back(e);
  endtask

  task automatic step(in_t v);
    @(posedge clk);
    #1;
    apply(v);
    model_step(v);
  endtask

  task automatic lit(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, got, exp);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    out_t g, e;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g.pc_en = pc_enable; g.ifid_en = if_id_enable; g.ifid_clr = if_id_clr;
      g.idex_en = id_ex_enable; g.idex_clr = id_ex_clr; g.back_en = back_enable;
      g.fa = forward_a; g.fb = forward_b; g.timeout = mem_timeout;
      g.state = (dut_state == ST_MEM_WAIT);
      g.stall = stall_count; g.flush = flush_count; g.waitc = wait_count;
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL cycle_outputs cyc=%0d got=%h expected=%h", cyc, g, e);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    in_t v;
    int burst;
    apply(idle());
    rst = 1'b1;
    m_was_busy = 0; m_busy_run = 0; m_timeout = 0; m_stall = 0; m_flush = 0; m_waitc = 0;

    v = idle(); v.rst = 1;
    step(v); step(v);
    step(idle());
    @(negedge clk);
    lit("reset_state", int'(dut_state), int'(ST_RUN));
    lit("reset_stall_count", int'(stall_count), 0);
    lit("reset_pc_enable", int'(pc_enable), 1);
    lit("reset_timeout", int'(mem_timeout), 0);

    // lw R2 in EX, add reading R2 in ID
    v = idle(); v.ex_mem_read = 1; v.ex_reg_write = 1; v.ex_wr = 3'd2; v.id_rs = 3'd2; v.uses_rs = 1;
    step(v);
    @(negedge clk);
    lit("loaduse_pc_enable", int'(pc_enable), 0);
    lit("loaduse_if_id_enable", int'(if_id_enable), 0);
    lit("loaduse_id_ex_clr", int'(id_ex_clr), 1);
    step(idle());
    @(negedge clk);
    lit("loaduse_stall_count", int'(stall_count), 1);

    // register zero never hazards or forwards
    v = idle(); v.ex_mem_read = 1; v.ex_reg_write = 1; v.ex_wr = 3'd0; v.id_rs = 3'd0; v.uses_rs = 1;
    v.mem_reg_write = 1; v.mem_wr = 3'd0; v.ex_rs = 3'd0;
    step(v);
    @(negedge clk);
    lit("zero_reg_pc_enable", int'(pc_enable), 1);
    lit("zero_reg_forward_a", int'(forward_a), 0);

    v = idle(); v.mem_reg_write = 1; v.mem_wr = 3'd3; v.wb_reg_write = 1; v.wb_wr = 3'd3; v.ex_rs = 3'd3;
    step(v);
    @(negedge clk);
    lit("fwd_mem_priority", int'(forward_a), 2);
    v.mem_reg_write = 0;
    step(v);
    @(negedge clk);
    lit("fwd_wb", int'(forward_a), 1);

    // branch beats load-use and jump
    v = idle(); v.branch = 1; v.jump = 1; v.ex_mem_read = 1; v.ex_reg_write = 1; v.ex_wr = 3'd4;
    v.id_rt = 3'd4; v.uses_rt = 1;
    step(v);
    @(negedge clk);
    lit("branch_if_id_clr", int'(if_id_clr), 1);
    lit("branch_id_ex_clr", int'(id_ex_clr), 1);
    lit("branch_pc_enable", int'(pc_enable), 1);
    step(idle());
    @(negedge clk);
    lit("branch_flush_count", int'(flush_count), 1);

    // five frozen cycles
    v = idle(); v.busy = 1;
    for (int i = 0; i < 5; i++) begin
      step(v);
      @(negedge clk);
      if (i == 1) lit("busy_state_wait", int'(dut_state), int'(ST_MEM_WAIT));
    end
    step(idle());
    @(negedge clk);
    lit("busy5_wait_count", int'(wait_count), 5);
    step(idle());
    @(negedge clk);
    lit("busy5_back_to_run", int'(dut_state), int'(ST_RUN));

    // timeout after 4 consecutive frozen cycles, cleared only by reset
    v = idle(); v.rst = 1;
    step(v);
    v = idle(); v.busy = 1;
    for (int i = 1; i <= 10; i++) begin
      step(v);
      @(negedge clk);
      if (i == 4) lit("timeout_not_yet", int'(mem_timeout), 0);
      if (i == 5) lit("timeout_set", int'(mem_timeout), 1);
    end
    v = idle(); v.rst = 1; v.busy = 1;
    step(v);
    @(negedge clk);
    lit("rst_mid_wait_pc_enable", int'(pc_enable), 1);
    v = idle(); v.busy = 1;
    step(v);
    @(negedge clk);
    lit("rst_mid_wait_state", int'(dut_state), int'(ST_RUN));
    lit("rst_clears_timeout", int'(mem_timeout), 0);

    // randomized phase
    burst = 0;
    for (int n = 0; n < 1500; n++) begin
      v.rst     = ($urandom_range(0, 99) == 0);
      v.branch  = ($urandom_range(0, 7) == 0);
      v.jump    = ($urandom_range(0, 5) == 0);
      v.uses_rs = 1'($urandom_range(0, 1));
      v.uses_rt = 1'($urandom_range(0, 1));
      v.ex_mem_read   = 1'($urandom_range(0, 1));
      v.ex_reg_write  = ($urandom_range(0, 3) != 0);
      v.mem_reg_write = 1'($urandom_range(0, 1));
      v.wb_reg_write  = 1'($urandom_range(0, 1));
      v.id_rs  = 3'($urandom_range(0, 3)); v.id_rt  = 3'($urandom_range(0, 3));
      v.ex_rs  = 3'($urandom_range(0, 3)); v.ex_rt  = 3'($urandom_range(0, 3));
      v.ex_wr  = 3'($urandom_range(0, 3)); v.mem_wr = 3'($urandom_range(0, 3));
      v.wb_wr  = 3'($urandom_range(0, 3));
      if (burst > 0) begin
        burst--;
        v.busy = 1;
      end else begin
        v.busy = ($urandom_range(0, 9) == 0);
        if ($urandom_range(0, 24) == 0) burst = $urandom_range(2, 7);
      end
      step(v);
    end
    step(idle());
    repeat (2) @(negedge clk);
    lit("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
